// File: rtl/binned_memory_writer.sv
// binned_memory_writer: writes binned stubs into one page of a 4x8x16 binned memory and maintains per-bin entry counts; optional drop counter under `BINNED_WRITER_OVF_CNT_EN
module binned_memory_writer #(
  parameter int RAM_WIDTH = 14,
  parameter int NENT_MAX  = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           page_i,
  input  logic                 stub_valid,
  output logic                 stub_ready,
  input  logic [2:0]           stub_bin,
  input  logic [RAM_WIDTH-1:0] stub_data,
  output logic [8:0]           addra,
  output logic [RAM_WIDTH-1:0] dina,
  output logic                 wea,
  output logic [31:0]          nent_we,
  output logic [127:0]         nent_o,
  output logic [1:0]           cur_page,
  output logic                 ovf,
  output logic [15:0]          ovf_cnt
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [3:0] NMAX = 4'(NENT_MAX);
  logic [0:0] state;
  logic [3:0] cnt [8];
  logic [3:0] c;
  logic [4:0] idx;
  logic       acc;
  logic       wr;
  logic       drop;
  assign stub_ready = (state == RUN) & ~start;
  assign acc        = stub_valid & stub_ready;
  assign c          = cnt[stub_bin];
  assign wr         = acc & (c < NMAX);
  assign drop       = acc & ~wr;
  assign idx        = {cur_page, stub_bin};
  // Registered write port, count write port, event state and bin counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wea      <= 1'b0;
      addra    <= '0;
      dina     <= '0;
      nent_we  <= '0;
      nent_o   <= '0;
      cur_page <= '0;
      ovf      <= 1'b0;
      cnt      <= '{default: '0};
    end else begin
      wea     <= wr;
      addra   <= wr ? {cur_page, stub_bin, c} : '0;
      dina    <= wr ? stub_data : '0;
      nent_we <= start ? 32'hFF << {page_i, 3'b000} : wr ? 32'd1 << idx : '0;
      nent_o  <= wr ? 128'(c + 4'd1) << {idx, 2'b00} : '0;
      if (start) begin
        state    <= RUN;
        cur_page <= page_i;
        cnt      <= '{default: '0};
        ovf      <= 1'b0;
      end else begin
        if (wr) cnt[stub_bin] <= c + 4'd1;
        if (drop) ovf <= 1'b1;
      end
    end
  end
`ifdef BINNED_WRITER_OVF_CNT_EN
  // Saturating count of dropped stubs since reset
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_cnt <= '0;
    else if (drop && !(&ovf_cnt)) ovf_cnt <= ovf_cnt + 16'd1;
  end
`else
  assign ovf_cnt = '0;
`endif
endmodule

// File: tb/tb_binned_memory_writer.sv
// tb_binned_memory_writer: randomized, model-checked bench for binned_memory_writer
module tb_binned_memory_writer;
  localparam int NMAX = 15;
  logic         clk = 0;
  logic         rst_n = 0;
  logic         start = 0;
  logic [1:0]   page_i = 0;
  logic         stub_valid = 0;
  logic         stub_ready;
  logic [2:0]   stub_bin = 0;
  logic [13:0]  stub_data = 0;
  logic [8:0]   addra;
  logic [13:0]  dina;
  logic         wea;
  logic [31:0]  nent_we;
  logic [127:0] nent_o;
  logic [1:0]   cur_page;
  logic         ovf;
  logic [15:0]  ovf_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  // behavioural model state
  bit   m_run;
  int   m_page;
  int   m_cnt [8];
  bit   m_ovf;
  int   m_drops;
  // expectations for the cycle just clocked
  logic         e_ready, got_ready, e_wea;
  logic [8:0]   e_addra;
  logic [13:0]  e_dina;
  logic [31:0]  e_we;
  logic [127:0] e_no;
  logic [15:0]  e_oc;

  binned_memory_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .page_i(page_i),
    .stub_valid(stub_valid), .stub_ready(stub_ready), .stub_bin(stub_bin),
    .stub_data(stub_data), .addra(addra), .dina(dina), .wea(wea),
    .nent_we(nent_we), .nent_o(nent_o), .cur_page(cur_page), .ovf(ovf),
    .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_oc();
`ifdef BINNED_WRITER_OVF_CNT_EN
    e_oc = 16'(m_drops);
`else
    e_oc = 16'd0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    start = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    m_run = 0; m_page = 0; m_ovf = 0; m_drops = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    e_wea = 0; e_addra = 0; e_dina = 0; e_we = 0; e_no = 0;
    model_oc();
  endtask

  task automatic step(input logic st, input logic [1:0] pg, input logic v,
                      input logic [2:0] b, input logic [13:0] d);
    int c, k;
    @(negedge clk);
    start = st; page_i = pg; stub_valid = v; stub_bin = b; stub_data = d;
    #1;
    got_ready = stub_ready;
    e_ready = m_run && !st;
    e_wea = 0; e_addra = 0; e_dina = 0; e_we = 0; e_no = 0;
    if (st) begin
      e_we = 32'hFF << (8 * int'(pg));
      m_run = 1; m_page = int'(pg); m_ovf = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else if (m_run && v) begin
      c = m_cnt[b];
      k = m_page * 8 + int'(b);
      if (c < NMAX) begin
        e_wea = 1;
        e_addra = 9'(m_page * 128 + int'(b) * 16 + c);
        e_dina = d;
        e_we = 32'd1 << k;
        e_no = 128'(c + 1) << (4 * k);
        m_cnt[b] = c + 1;
      end else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
    model_oc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({wea, addra, dina, nent_we, nent_o, cur_page, ovf, ovf_cnt, stub_ready} !== '0) begin
      n_bad++; $display("FAIL reset_outputs wea=%b addra=%h nent_we=%h ready=%b ovf_cnt=%h", wea, addra, nent_we, stub_ready, ovf_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 2'($urandom), 1, 3'($urandom), 14'($urandom));
      n_cmp++; if (got_ready !== 1'b0 || wea !== 1'b0 || nent_we !== 32'd0) begin
        n_bad++; $display("FAIL idle_no_accept ready=%b wea=%b nent_we=%h exp 0/0/0", got_ready, wea, nent_we);
      end
    end
  endtask

  task automatic test_bin_burst();
    step(1, 2, 0, 0, 0);
    n_cmp++; if (nent_we !== 32'h00FF0000 || nent_o !== '0 || wea !== 1'b0) begin
      n_bad++; $display("FAIL page2_clear nent_we=%h nent_o=%h wea=%b exp 00ff0000/0/0", nent_we, nent_o, wea);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 5, 14'(16'h101 + i));
      n_cmp++; if (got_ready !== 1'b1 || wea !== 1'b1 || addra !== 9'(9'h150 + i) || dina !== 14'(16'h101 + i)) begin
        n_bad++; $display("FAIL burst_write%0d ready=%b wea=%b addra=%h dina=%h exp 1/1/%h/%h", i, got_ready, wea, addra, dina, 9'h150 + i, 16'h101 + i);
      end
      n_cmp++; if (nent_we !== 32'h0020_0000 || nent_o[87:84] !== 4'(i + 1) || nent_o !== e_no) begin
        n_bad++; $display("FAIL burst_count%0d nent_we=%h slice=%0d exp 00200000/%0d", i, nent_we, nent_o[87:84], i + 1);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0, 14'($urandom));
      if (i < 15) begin
        n_cmp++; if (wea !== 1'b1 || addra !== 9'(i) || dina !== e_dina || nent_o[3:0] !== 4'(i + 1)) begin
          n_bad++; $display("FAIL ovf_fill%0d wea=%b addra=%h nent_o=%0d exp 1/%h/%0d", i, wea, addra, nent_o[3:0], i, i + 1);
        end
      end else begin
        n_cmp++; if (wea !== 1'b0 || nent_we !== 32'd0) begin
          n_bad++; $display("FAIL ovf_drop wea=%b nent_we=%h exp 0/0", wea, nent_we);
        end
      end
    end
    n_cmp++; if (ovf !== 1'b1 || ovf_cnt !== e_oc) begin
      n_bad++; $display("FAIL ovf_flag ovf=%b ovf_cnt=%0d exp 1/%0d", ovf, ovf_cnt, e_oc);
    end
  endtask

  task automatic test_start_priority();
    step(1, 1, 1, 3, 14'h2AB);
    n_cmp++; if (got_ready !== 1'b0 || nent_we !== 32'h0000FF00 || nent_o !== '0 || wea !== 1'b0 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL start_priority ready=%b nent_we=%h wea=%b ovf=%b exp 0/0000ff00/0/0", got_ready, nent_we, wea, ovf);
    end
    step(0, 0, 1, 3, 14'h2AB);
    n_cmp++; if (got_ready !== 1'b1 || wea !== 1'b1 || addra !== 9'h0B0 || dina !== 14'h2AB || cur_page !== 2'd1) begin
      n_bad++; $display("FAIL after_start ready=%b wea=%b addra=%h dina=%h exp 1/1/0b0/2ab", got_ready, wea, addra, dina);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 1, 6, 14'h3C);
    step(1, 0, 0, 0, 0);
    n_cmp++; if (wea !== 1'b0 || nent_we !== 32'h000000FF) begin
      n_bad++; $display("FAIL start_after_write wea=%b nent_we=%h exp 0/000000ff", wea, nent_we);
    end
    step(1, 3, 0, 0, 0);
    n_cmp++; if (nent_we !== 32'hFF000000 || nent_o !== '0) begin
      n_bad++; $display("FAIL double_start nent_we=%h exp ff000000", nent_we);
    end
    step(0, 0, 1, 7, 14'h1);
    n_cmp++; if (wea !== 1'b1 || addra !== 9'h1F0) begin
      n_bad++; $display("FAIL page3_first wea=%b addra=%h exp 1/1f0", wea, addra);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 1, 7, 14'h2);
    @(negedge clk);
    rst_n = 0;
    stub_valid = 1;
    @(posedge clk);
    #1;
    n_cmp++; if ({wea, addra, dina, nent_we, nent_o, cur_page, ovf, ovf_cnt, stub_ready} !== '0) begin
      n_bad++; $display("FAIL reset_mid wea=%b addra=%h nent_we=%h ready=%b", wea, addra, nent_we, stub_ready);
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 3'($urandom), 14'($urandom));
      n_cmp++; if (wea !== 1'b0 || got_ready !== 1'b0 || nent_we !== 32'd0) begin
        n_bad++; $display("FAIL post_reset_idle wea=%b ready=%b nent_we=%h exp 0/0/0", wea, got_ready, nent_we);
      end
    end
  endtask

  task automatic test_random();
    logic st, v;
    logic [2:0] b;
    for (int i = 0; i < 600; i++) begin
      st = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 1)) : 3'($urandom);
      step(st, 2'($urandom), v, b, 14'($urandom));
      n_cmp++; if (got_ready !== e_ready || wea !== e_wea || addra !== e_addra || dina !== e_dina) begin
        n_bad++; $display("FAIL rand_write%0d ready=%b/%b wea=%b/%b addra=%h/%h dina=%h/%h", i, got_ready, e_ready, wea, e_wea, addra, e_addra, dina, e_dina);
      end
      n_cmp++; if (nent_we !== e_we || nent_o !== e_no || ovf !== m_ovf || ovf_cnt !== e_oc || cur_page !== 2'(m_page)) begin
        n_bad++; $display("FAIL rand_count%0d nent_we=%h/%h nent_o=%h/%h ovf=%b/%b ovf_cnt=%0d/%0d", i, nent_we, e_we, nent_o, e_no, ovf, m_ovf, ovf_cnt, e_oc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bin_burst();
    test_overflow();
    test_start_priority();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
